// File: rtl/nonce_scheduler.sv
// Nonce scheduler for the SHA-256 miner: issues an ascending nonce range into the core,
// tracks in-flight hashes, captures the first hit and pulses done when the run drains.
module nonce_scheduler #(
  parameter int WORD_S       = 32,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_S-1:0] nonce_first,
  input  logic [WORD_S-1:0] nonce_last,
  input  logic              core_ready,
  output logic              core_en,
  output logic [WORD_S-1:0] core_nonce,
  input  logic              res_valid,
  input  logic [WORD_S-1:0] res_nonce,
  input  logic              res_hit,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [WORD_S-1:0] found_nonce,
  output logic              aborted
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [WORD_S-1:0] next_nonce, last_nonce;
  logic [CNT_W-1:0]  inflight, inflight_next;
  logic              active, res_take, hit_take, range_empty, issue;

  // Results are only meaningful while something is outstanding; a hit or abort in the
  // decision cycle suppresses that cycle's issue.
  always_comb begin
    active        = (state == ISSUE) || (state == DRAIN);
    res_take      = res_valid && (state != IDLE) && (inflight != '0);
    hit_take      = res_take && res_hit && active && !found;
    range_empty   = next_nonce > last_nonce;
    issue         = (state == ISSUE) && core_ready && !range_empty && !hit_take && !abort &&
                    (inflight < CNT_W'(MAX_INFLIGHT));
    inflight_next = inflight;
    if (issue && !res_take)
      inflight_next = inflight + CNT_W'(1);
    else if (!issue && res_take)
      inflight_next = inflight - CNT_W'(1);

    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (hit_take || abort || range_empty || (issue && next_nonce == last_nonce))
                 state_next = DRAIN;
      DRAIN:   if (inflight_next == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The counter never steps past nonce_last, so an all-ones range end cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_en     <= 1'b0;
      core_nonce  <= '0;
      next_nonce  <= '0;
      last_nonce  <= '0;
      inflight    <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      aborted     <= 1'b0;
    end else begin
      core_en  <= issue;
      inflight <= inflight_next;
      if (issue) begin
        core_nonce <= next_nonce;
        if (next_nonce != last_nonce) next_nonce <= next_nonce + WORD_S'(1);
      end
      if (state == IDLE && start) begin
        next_nonce  <= nonce_first;
        last_nonce  <= nonce_last;
        found       <= 1'b0;
        found_nonce <= '0;
        aborted     <= 1'b0;
      end
      if (hit_take) begin
        found       <= 1'b1;
        found_nonce <= res_nonce;
      end
      if (abort && active && !found && !hit_take) aborted <= 1'b1;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboard bench for nonce_scheduler: directed runs push expected issues and run
// outcomes; a monitor compares them as the DUT presents core_en and done.
module tb_nonce_scheduler;

  localparam int W    = 32;
  localparam int MAXI = 4;

  logic         clk = 1'b0;
  logic         reset, start, abort, core_ready;
  logic [W-1:0] nonce_first, nonce_last;
  logic         core_en;
  logic [W-1:0] core_nonce;
  logic         res_valid = 1'b0;
  logic [W-1:0] res_nonce = '0;
  logic         res_hit = 1'b0;
  logic         busy, done, found, aborted;
  logic [W-1:0] found_nonce;

  always #5 clk = ~clk;

  nonce_scheduler #(.WORD_S(W), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .nonce_first(nonce_first), .nonce_last(nonce_last), .core_ready(core_ready),
    .core_en(core_en), .core_nonce(core_nonce),
    .res_valid(res_valid), .res_nonce(res_nonce), .res_hit(res_hit),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce), .aborted(aborted)
  );

  typedef struct packed {logic f; logic [W-1:0] fn; logic ab;} fin_t;
  typedef struct {logic [W-1:0] n; int c;} pend_t;

  logic [W-1:0] exp_q[$];
  fin_t         done_q[$];
  pend_t        pq[$];

  int           n_checks = 0, n_fail = 0, issue_cnt = 0, cyc = 0;
  int           lat = 4, rel_req = 0, rel_done = 0;
  logic         hold = 1'b0, hit_en = 1'b0;
  logic [W-1:0] hit_a = '0, hit_b = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic e_busy, input logic e_found,
                              input logic [W-1:0] e_fn, input logic e_ab);
    check({tag, "_busy"}, W'(busy), W'(e_busy));
    check({tag, "_found"}, W'(found), W'(e_found));
    check({tag, "_found_nonce"}, found_nonce, e_fn);
    check({tag, "_aborted"}, W'(aborted), W'(e_ab));
  endtask

  // Core model: returns each issued nonce in order after lat cycles, optionally withheld.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      res_valid = 1'b0;
      res_hit   = 1'b0;
      if (pq.size() > 0 && cyc >= pq[0].c + lat && (!hold || rel_req > rel_done)) begin
        res_valid = 1'b1;
        res_nonce = pq[0].n;
        res_hit   = hit_en && (pq[0].n == hit_a || pq[0].n == hit_b);
        if (hold) rel_done++;
        void'(pq.pop_front());
      end
      if (core_en) pq.push_back('{core_nonce, cyc});
    end
  end

  // Monitor: every issue and every done pulse consumes one scoreboard entry.
  fin_t         mon_f;
  logic [W-1:0] mon_n;
  initial begin
    forever begin
      @(negedge clk);
      if (core_en) begin
        issue_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL issue_unexpected: got core_nonce 0x%0h, expected no issue", core_nonce);
        end else begin
          mon_n = exp_q.pop_front();
          check("core_nonce", core_nonce, mon_n);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL done_unexpected: got done=1, expected no done");
        end else begin
          mon_f = done_q.pop_front();
          check("done_found", W'(found), W'(mon_f.f));
          check("done_found_nonce", found_nonce, mon_f.fn);
          check("done_aborted", W'(aborted), W'(mon_f.ab));
          check("done_busy", W'(busy), W'(1'b1));
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [W-1:0] first, input logic [W-1:0] last);
    nonce_first = first;
    nonce_last  = last;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic push_range(input logic [W-1:0] first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(first + W'(i));
  endtask

  task automatic wait_done(input int limit, input string name);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done) break;
    end
    n_checks++;
    if (k == limit) begin
      n_fail++;
      $display("[TB] FAIL %s: got no done within %0d cycles, expected a done pulse", name, limit);
    end
    @(negedge clk);
  endtask

  task automatic wait_issue(input logic [W-1:0] n, input int limit, input string name);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (core_en && core_nonce == n) break;
    end
    n_checks++;
    if (k == limit) begin
      n_fail++;
      $display("[TB] FAIL %s: got no issue of 0x%0h within %0d cycles, expected one", name, n, limit);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, run_len;
    reset = 1'b1; start = 1'b0; abort = 1'b0; core_ready = 1'b1;
    nonce_first = '0; nonce_last = '0;
    repeat (3) @(negedge clk);
    check("reset_core_en", W'(core_en), W'(1'b0));
    check("reset_core_nonce", core_nonce, '0);
    check("reset_done", W'(done), W'(1'b0));
    check_output("reset", 1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] run 1: range 0x10..0x13, no hits");
    lat = 4; hit_en = 1'b0;
    push_range(32'h10, 4);
    done_q.push_back('{1'b0, 32'h0, 1'b0});
    apply_stimulus(32'h10, 32'h13);
    wait_issue(32'h10, 20, "t1_first_issue");
    run_len = 1;
    repeat (3) begin
      @(negedge clk);
      if (core_en) run_len++;
    end
    check("t1_consecutive", W'(run_len), W'(4));
    wait_done(50, "t1_done");
    check_output("t1_end", 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] run 2: range 0..0xFF, hits on 0x20 and 0x21, start while busy");
    lat = 2; hit_en = 1'b1; hit_a = 32'h20; hit_b = 32'h21;
    push_range(32'h0, 32'h23);
    done_q.push_back('{1'b1, 32'h20, 1'b0});
    apply_stimulus(32'h0, 32'hFF);
    wait_issue(32'h5, 20, "t2_issue5");
    apply_stimulus(32'h100, 32'h100);
    wait_done(200, "t2_done");
    repeat (3) @(negedge clk);
    check_output("t2_end", 1'b0, 1'b1, 32'h20, 1'b0);

    $display("[TB] run 3: range FFFFFFFE..FFFFFFFF");
    hit_en = 1'b0;
    push_range(32'hFFFF_FFFE, 2);
    done_q.push_back('{1'b0, 32'h0, 1'b0});
    apply_stimulus(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    wait_done(50, "t3_done");
    repeat (5) @(negedge clk);
    check_output("t3_end", 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] run 4: in-flight cap with withheld results");
    lat = 4; hold = 1'b1; rel_req = 0; rel_done = 0;
    push_range(32'h0, 8);
    done_q.push_back('{1'b0, 32'h0, 1'b0});
    base = issue_cnt;
    apply_stimulus(32'h0, 32'h7);
    repeat (12) @(negedge clk);
    check("t4_cap", W'(issue_cnt - base), W'(4));
    rel_req = rel_req + 1;
    repeat (8) @(negedge clk);
    check("t4_one_release", W'(issue_cnt - base), W'(5));
    rel_req = rel_req + 2;
    repeat (8) @(negedge clk);
    check("t4_same_cycle", W'(issue_cnt - base), W'(7));
    hold = 1'b0;
    wait_done(100, "t4_done");

    $display("[TB] run 5: abort at the 10th issue");
    lat = 2;
    push_range(32'h0, 10);
    done_q.push_back('{1'b0, 32'h0, 1'b1});
    apply_stimulus(32'h0, 32'h3FF);
    wait_issue(32'h9, 30, "t5_issue9");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(50, "t5_done");
    check_output("t5_end", 1'b0, 1'b0, '0, 1'b1);

    $display("[TB] run 6: reset mid-run with stale hit results");
    lat = 4; hit_en = 1'b1; hit_a = 32'h1; hit_b = 32'h1;
    push_range(32'h0, 3);
    apply_stimulus(32'h0, 32'h3FF);
    wait_issue(32'h2, 20, "t6_issue2");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_core_en", W'(core_en), W'(1'b0));
    check("t6_core_nonce", core_nonce, '0);
    check_output("t6_reset", 1'b0, 1'b0, '0, 1'b0);
    repeat (10) @(negedge clk);
    check_output("t6_stale", 1'b0, 1'b0, '0, 1'b0);
    hit_en = 1'b0;
    push_range(32'h5, 1);
    done_q.push_back('{1'b0, 32'h0, 1'b0});
    apply_stimulus(32'h5, 32'h5);
    wait_done(30, "t6_done");

    $display("[TB] run 7: empty range 9..5");
    done_q.push_back('{1'b0, 32'h0, 1'b0});
    apply_stimulus(32'h9, 32'h5);
    wait_done(20, "t7_done");
    repeat (3) @(negedge clk);

    check("issues_left", W'(exp_q.size()), W'(0));
    check("dones_left", W'(done_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
